// File: rtl/pipeline_ctrl.sv
// Pipeline control: stall vector arbitration, flush/redirect sequencing,
// stall watchdog and saturating performance counters.
module pipeline_ctrl #(
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stallreq_if_i,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic             stallreq_mem_i,
    input  logic             branch_mispredict_i,
    input  logic [31:0]      branch_target_i,
    input  logic             trap_i,
    input  logic             mret_i,
    input  logic [31:0]      mtvec_i,
    input  logic [31:0]      mepc_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic             branch_flush_o,
    output logic [31:0]      new_pc_o,
    output logic             hang_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam int unsigned WD_W   = 17;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT);

    typedef enum logic [1:0] {
        RUN,
        WAIT_MEM,
        FLUSH,
        BFLUSH
    } state_t;

    state_t          state;
    logic [31:0]     target;
    logic [WD_W-1:0] wd;

    logic [5:0]  decode;
    logic [5:0]  stall_n;
    logic        sys_evt;
    logic [31:0] sys_target;

    assign sys_evt    = trap_i | mret_i;
    assign sys_target = trap_i ? mtvec_i : mepc_i;

    always_comb begin
        decode = STALL_NONE;
        if (stallreq_mem_i) begin
            decode = STALL_MEM;
        end else if (stallreq_ex_i) begin
            decode = STALL_EX;
        end else if (stallreq_id_i) begin
            decode = STALL_ID;
        end else if (stallreq_if_i) begin
            decode = STALL_IF;
        end
    end

    // A redirect being accepted must freeze the front end behind it.
    always_comb begin
        stall_n = STALL_NONE;
        unique case (state)
            RUN: begin
                if (sys_evt && !stallreq_mem_i) begin
                    stall_n = STALL_EX;
                end else if (!sys_evt && branch_mispredict_i &&
                             !stallreq_mem_i && !stallreq_ex_i) begin
                    stall_n = STALL_ID;
                end else begin
                    stall_n = decode;
                end
            end
            WAIT_MEM: stall_n = STALL_MEM;
            FLUSH:    stall_n = STALL_NONE;
            BFLUSH:   stall_n = decode;
            default:  stall_n = STALL_NONE;
        endcase
    end

    assign stall_o = rst_i ? STALL_NONE : stall_n;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= RUN;
            target         <= '0;
            flush_o        <= 1'b0;
            branch_flush_o <= 1'b0;
            new_pc_o       <= '0;
        end else begin
            flush_o        <= 1'b0;
            branch_flush_o <= 1'b0;
            unique case (state)
                RUN: begin
                    if (sys_evt) begin
                        target <= sys_target;
                        if (stallreq_mem_i) begin
                            state <= WAIT_MEM;
                        end else begin
                            state    <= FLUSH;
                            flush_o  <= 1'b1;
                            new_pc_o <= sys_target;
                        end
                    end else if (branch_mispredict_i) begin
                        target         <= branch_target_i;
                        state          <= BFLUSH;
                        branch_flush_o <= 1'b1;
                        new_pc_o       <= branch_target_i;
                    end
                end
                WAIT_MEM: begin
                    if (!stallreq_mem_i) begin
                        state    <= FLUSH;
                        flush_o  <= 1'b1;
                        new_pc_o <= target;
                    end
                end
                FLUSH:   state <= RUN;
                BFLUSH:  state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Watchdog saturates at the timeout so hang stays meaningful.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd     <= '0;
            hang_o <= 1'b0;
        end else if (stall_o != STALL_NONE) begin
            if (wd != WD_MAX) begin
                wd <= wd + 1'b1;
                if (wd == WD_MAX - 1'b1) begin
                    hang_o <= 1'b1;
                end
            end
        end else begin
            wd <= '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cycles_o <= '0;
            flush_count_o  <= '0;
        end else begin
            if (stall_o != STALL_NONE && stall_cycles_o != '1) begin
                stall_cycles_o <= stall_cycles_o + 1'b1;
            end
            if ((flush_o || branch_flush_o) && flush_count_o != '1) begin
                flush_count_o <= flush_count_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: stall vector table, flush
// scoreboard, watchdog, reset and counter saturation sequences.
module tb_pipeline_ctrl;

    localparam int unsigned TMO = 8;
    localparam int unsigned CW  = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rq_if, rq_id, rq_ex, rq_mem;
    logic          bm;
    logic [31:0]   bt;
    logic          trap, mret;
    logic [31:0]   mtvec, mepc;
    logic [5:0]    stall;
    logic          flush, bflush;
    logic [31:0]   new_pc;
    logic          hang;
    logic [CW-1:0] stall_cycles, flush_count;

    pipeline_ctrl #(
        .STALL_TIMEOUT(TMO),
        .CNT_W(CW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .stallreq_if_i(rq_if),
        .stallreq_id_i(rq_id),
        .stallreq_ex_i(rq_ex),
        .stallreq_mem_i(rq_mem),
        .branch_mispredict_i(bm),
        .branch_target_i(bt),
        .trap_i(trap),
        .mret_i(mret),
        .mtvec_i(mtvec),
        .mepc_i(mepc),
        .stall_o(stall),
        .flush_o(flush),
        .branch_flush_o(bflush),
        .new_pc_o(new_pc),
        .hang_o(hang),
        .stall_cycles_o(stall_cycles),
        .flush_count_o(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       bm;
        logic       tr;
        logic       mr;
        logic [5:0] exp_stall;
    } vec_t;

    typedef struct {
        logic        full;
        logic [31:0] pc;
        int          cyc;
    } fexp_t;

    vec_t  vecs[14];
    fexp_t fq[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    cyc    = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(logic [3:0] r, logic b, logic [31:0] t,
                          logic tr, logic mr);
        rq_mem = r[3];
        rq_ex  = r[2];
        rq_id  = r[1];
        rq_if  = r[0];
        bm     = b;
        bt     = t;
        trap   = tr;
        mret   = mr;
    endtask

    task automatic idle();
        set_in(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic push(logic full, logic [31:0] pc, int dly);
        fexp_t e;
        e.full = full;
        e.pc   = pc;
        e.cyc  = cyc + dly;
        fq.push_back(e);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(int max);
        int k = 0;
        while (fq.size() != 0 && k < max) begin
            tick();
            k++;
        end
        chk("sb_drain", fq.size(), 0);
    endtask

    // Scoreboard: every flush pulse must match the oldest pending redirect.
    always @(posedge clk) begin
        fexp_t e;
        cyc = cyc + 1;
        #1;
        if (!rst && (flush || bflush)) begin
            chk("flush_exclusive", {31'd0, flush & bflush}, 0);
            if (fq.size() == 0) begin
                chk("unexpected_flush", {30'd0, flush, bflush}, 0);
            end else begin
                e = fq.pop_front();
                chk("flush_kind", {31'd0, flush}, {31'd0, e.full});
                chk("flush_pc", new_pc, e.pc);
                chk("flush_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n_stall;
        int n_evt;
        logic [31:0] pc;

        mtvec = 32'h8000_0100;
        mepc  = 32'h0000_2000;
        idle();

        vecs[0]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[1]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 6'b000011};
        vecs[2]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 6'b000111};
        vecs[3]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 6'b001111};
        vecs[4]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 6'b011111};
        vecs[5]  = '{4'b0110, 1'b0, 1'b0, 1'b0, 6'b001111};
        vecs[6]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 6'b011111};
        vecs[7]  = '{4'b0011, 1'b0, 1'b0, 1'b0, 6'b000111};
        vecs[8]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 6'b000111};
        vecs[9]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 6'b000111};
        vecs[10] = '{4'b0100, 1'b1, 1'b0, 1'b0, 6'b001111};
        vecs[11] = '{4'b1000, 1'b1, 1'b0, 1'b0, 6'b011111};
        vecs[12] = '{4'b0000, 1'b0, 1'b1, 1'b0, 6'b001111};
        vecs[13] = '{4'b0010, 1'b0, 1'b0, 1'b1, 6'b001111};

        // reset state
        tick();
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        chk("rst_bflush", bflush, 0);
        chk("rst_new_pc", new_pc, 0);
        chk("rst_hang", hang, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        chk("rst_flush_count", flush_count, 0);
        rst = 1'b0;
        tick();

        // stall priority / event forcing table
        n_stall = 0;
        n_evt   = 0;
        for (int i = 0; i < 14; i++) begin
            pc = 32'h1000 + 32'(i * 4);
            set_in(vecs[i].req, vecs[i].bm, pc, vecs[i].tr, vecs[i].mr);
            #1;
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
            if (vecs[i].exp_stall != 6'd0) n_stall++;
            if (vecs[i].tr) begin
                push(1'b1, mtvec, 1);
                n_evt++;
            end else if (vecs[i].mr) begin
                push(1'b1, mepc, 1);
                n_evt++;
            end else if (vecs[i].bm) begin
                push(1'b0, pc, 1);
                n_evt++;
            end
            tick();
            idle();
            #1;
            chk($sformatf("vec%0d_post_stall", i), stall, 0);
            tick();
        end
        chk("tbl_stall_cycles", stall_cycles, n_stall);
        chk("tbl_flush_count", flush_count, n_evt);
        chk("tbl_hang", hang, 0);
        drain(4);

        // trap with mem stall low
        do_reset();
        set_in(4'b0000, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("trap_stall", stall, 6'b001111);
        push(1'b1, mtvec, 1);
        tick();
        idle();
        #1;
        chk("trap_flush", flush, 1);
        chk("trap_pc", new_pc, mtvec);
        chk("trap_flush_stall", stall, 0);
        tick();
        chk("trap_flush_once", flush, 0);
        chk("trap_count", flush_count, 1);

        // trap held off by mem stall; events during WAIT_MEM ignored
        set_in(4'b1000, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("tmem_stall_t0", stall, 6'b011111);
        push(1'b1, mtvec, 5);
        tick();
        for (int k = 1; k <= 3; k++) begin
            set_in(4'b1000, k == 2, 32'h4444, 1'b0, k == 1);
            #1;
            chk($sformatf("tmem_stall_t%0d", k), stall, 6'b011111);
            chk($sformatf("tmem_noflush_t%0d", k), flush, 0);
            tick();
        end
        idle();
        tick();
        chk("tmem_flush", flush, 1);
        chk("tmem_pc", new_pc, mtvec);
        tick();
        drain(4);

        // simultaneous trap, mret and mispredict
        set_in(4'b0000, 1'b1, 32'h3000, 1'b1, 1'b1);
        #1;
        chk("sim_stall", stall, 6'b001111);
        push(1'b1, mtvec, 1);
        tick();
        idle();
        #1;
        chk("sim_flush", flush, 1);
        chk("sim_no_bflush", bflush, 0);
        chk("sim_pc", new_pc, mtvec);
        tick();
        chk("sim_after_bflush", bflush, 0);

        // branch, second mispredict in BFLUSH ignored
        set_in(4'b0000, 1'b1, 32'h1234, 1'b0, 1'b0);
        push(1'b0, 32'h1234, 1);
        tick();
        set_in(4'b0100, 1'b1, 32'h5678, 1'b0, 1'b0);
        #1;
        chk("br_bflush", bflush, 1);
        chk("br_pc", new_pc, 32'h1234);
        chk("br_bflush_stall", stall, 6'b001111);
        tick();
        idle();
        #1;
        chk("br_second_ignored", bflush, 0);
        chk("br_pc_hold", new_pc, 32'h1234);
        tick();
        drain(4);

        // watchdog
        do_reset();
        set_in(4'b0100, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (7) tick();
        idle();
        #1;
        chk("wd7_hang", hang, 0);
        tick();
        set_in(4'b0100, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) chk("wd_pre_hang", hang, 0);
        end
        chk("wd8_hang", hang, 1);
        idle();
        tick();
        tick();
        chk("wd_sticky", hang, 1);
        chk("wd_stall_cycles", stall_cycles, 15);

        // reset during WAIT_MEM discards the redirect
        set_in(4'b0000, 1'b1, 32'h0abc, 1'b0, 1'b0);
        push(1'b0, 32'h0abc, 1);
        tick();
        idle();
        tick();
        set_in(4'b1100, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rstw_stall", stall, 0);
        chk("rstw_flush", flush, 0);
        chk("rstw_bflush", bflush, 0);
        chk("rstw_new_pc", new_pc, 0);
        chk("rstw_hang", hang, 0);
        chk("rstw_stall_cycles", stall_cycles, 0);
        chk("rstw_flush_count", flush_count, 0);
        idle();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rstw_no_flush", flush_count, 0);

        // reset during FLUSH
        set_in(4'b0000, 1'b0, 32'h0, 1'b1, 1'b0);
        push(1'b1, mtvec, 1);
        tick();
        idle();
        #1;
        rst = 1'b1;
        #1;
        chk("rstf_flush", flush, 0);
        chk("rstf_new_pc", new_pc, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rstf_no_flush", flush_count, 0);

        // counter saturation
        set_in(4'b0010, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (70) tick();
        idle();
        #1;
        chk("sat_stall_cycles", stall_cycles, 63);
        tick();
        for (int k = 0; k < 70; k++) begin
            set_in(4'b0000, 1'b1, 32'(k * 8), 1'b0, 1'b0);
            push(1'b0, 32'(k * 8), 1);
            tick();
            idle();
            tick();
        end
        tick();
        chk("sat_flush_count", flush_count, 63);
        drain(4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
